mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the instruction-fetch stage and the MEM stage of the 5-stage pipelined processor.
- Data (MEM-stage) accesses normally win; a starvation limit guarantees fetch progress.
- Exports per-requester stall signals to the hazard detection unit.
- Exactly one memory transaction is outstanding at a time.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_arb_prio_sel.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
// Imported by the bus interface, the priority selector and the arbiter top.
package mem_arb_pkg;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int INSTR_W  = 32;
    localparam int STARVE_W = 4;
    localparam int LAT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the MEM stage, the arbiter and the
// unified memory. The arbiter connects through the slave modport; the
// requester/memory side uses the master modport.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic                 if_req;
    logic [ADDR_W-1:0]    if_addr;
    logic                 if_gnt;
    logic                 if_rvalid;
    logic [INSTR_W-1:0]   if_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [ADDR_W-1:0]    d_addr;
    logic [DATA_W-1:0]    d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;
    logic [DATA_W-1:0]    d_rdata;

    logic                 m_req;
    logic                 m_we;
    logic [ADDR_W-1:0]    m_addr;
    logic [DATA_W-1:0]    m_wdata;
    logic [DATA_W-1:0]    m_rdata;

    logic                 stall_if;
    logic                 stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, stall_if, stall_mem
    );

endinterface

// File: rtl/mem_arb_prio_sel.sv
// Priority pick between fetch and data requests. Data normally wins, but
// once MAX_DATA_BURST data grants have gone by while fetch was waiting,
// fetch wins the next arbitration. Grants only happen while the arbiter idles.
module mem_arb_prio_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 3
) (
    input  logic                Clk,
    input  logic                resetl,
    input  logic                idle,
    input  logic                if_req,
    input  logic                d_req,
    output logic                if_gnt,
    output logic                d_gnt,
    output logic [STARVE_W-1:0] starve
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_DATA_BURST);

    // Combinational grant: data first unless fetch has been starved long enough.
    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (idle) begin
            if (d_req && !(if_req && (starve == STARVE_MAX))) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Count data grants that overtook a waiting fetch, saturating at the limit.
    always_ff @(posedge Clk) begin
        if (!resetl) begin
            starve <= '0;
        end else if (if_gnt || (idle && !if_req)) begin
            starve <= '0;
        end else if (d_gnt && if_req && (starve < STARVE_MAX)) begin
            starve <= starve + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch
// and the MEM stage. One transaction is outstanding at a time:
// grant (IDLE) -> MEM_LAT cycles of ACCESS -> one DONE cycle with rvalid.
// Optional build macro MEM_ARB_PERF_CNT_EN adds two saturating performance
// counters (fetch wait cycles, IDLE-cycle request conflicts).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT        = 2,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic              Clk,
    input  logic              resetl,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_conflicts,
`endif
    mem_port_arbiter_if.slave bus
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    state_t               state;
    state_t               state_nxt;
    owner_t               owner;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 idle;
    logic                 if_gnt;
    logic                 d_gnt;
    logic [STARVE_W-1:0]  starve;

    logic                 m_req_q;
    logic                 m_we_q;
    logic [ADDR_W-1:0]    m_addr_q;
    logic [DATA_W-1:0]    m_wdata_q;
    logic [INSTR_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]    d_rdata_q;
    logic                 if_rvalid_q;
    logic                 d_rvalid_q;

    assign idle = (state == IDLE);

    mem_arb_prio_sel #(
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) u_prio_sel (
        .Clk    (Clk),
        .resetl (resetl),
        .idle   (idle),
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt),
        .starve (starve)
    );

    starve_bounded: assert property (@(posedge Clk) disable iff (!resetl)
        starve <= STARVE_W'(MAX_DATA_BURST));

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.stall_if  = bus.if_req & ~if_rvalid_q;
    assign bus.stall_mem = bus.d_req & ~d_rvalid_q;

    // State register; reset abandons any in-flight access.
    always_ff @(posedge Clk) begin
        if (!resetl) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a grant starts an access, the last latency cycle completes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (if_gnt || d_gnt) state_nxt = ACCESS;
            ACCESS:  if (lat_cnt == '0)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side latches, latency counter, read-data capture and rvalid pulses.
    always_ff @(posedge Clk) begin
        if (!resetl) begin
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            owner       <= OWN_IF;
            lat_cnt     <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        m_req_q   <= 1'b1;
                        m_we_q    <= bus.d_we;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        owner     <= OWN_D;
                        lat_cnt   <= LAT_LOAD;
                    end else if (if_gnt) begin
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.if_addr;
                        m_wdata_q <= '0;
                        owner     <= OWN_IF;
                        lat_cnt   <= LAT_LOAD;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        m_req_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        if (owner == OWN_D) begin
                            d_rvalid_q <= 1'b1;
                            if (!m_we_q) begin
                                d_rdata_q <= bus.m_rdata;
                            end
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= m_addr_q[2] ? bus.m_rdata[DATA_W-1:INSTR_W]
                                                       : bus.m_rdata[INSTR_W-1:0];
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    // Saturating counters: fetch wait cycles and IDLE cycles with both requesters asking.
    always_ff @(posedge Clk) begin
        if (!resetl) begin
            perf_if_wait   <= '0;
            perf_conflicts <= '0;
        end else begin
            if (bus.if_req && !if_gnt && (perf_if_wait != '1)) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end
            if (idle && bus.if_req && bus.d_req && (perf_conflicts != '1)) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level reference
// model tracks when the memory is free, who was granted and when each
// completion is due; outputs are compared on the falling clock edge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int MEM_LAT        = 2;
    localparam int MAX_DATA_BURST = 3;

    logic Clk    = 1'b0;
    logic resetl = 1'b0;

    mem_port_arbiter_if bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_conflicts;
`endif

    mem_port_arbiter #(
        .MEM_LAT        (MEM_LAT),
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) dut (
        .Clk            (Clk),
        .resetl         (resetl),
`ifdef MEM_ARB_PERF_CNT_EN
        .perf_if_wait   (perf_if_wait),
        .perf_conflicts (perf_conflicts),
`endif
        .bus            (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passed = 0;

    // Reference model state (cycle-numbered, transaction level).
    int          cyc          = 0;
    int          next_free    = 0;
    int          starve_m     = 0;
    bit          act          = 1'b0;
    bit          own_d        = 1'b0;
    int          gc           = 0;
    bit          p_we         = 1'b0;
    logic [63:0] p_addr       = '0;
    logic [63:0] p_wdata      = '0;
    logic [63:0] p_rdata      = '0;
    logic [31:0] exp_if_rdata = '0;
    logic [63:0] exp_d_rdata  = '0;
    logic [63:0] next_rdata   = '0;
    bit          last_gi      = 1'b0;
    bit          last_gd      = 1'b0;
    int          m_wait       = 0;
    int          m_conf       = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                     tag, cyc, actual, expected);
        end else begin
            passed++;
        end
    endtask

    // Randomly refresh requests; a request is held until it has been granted.
    task automatic applyStimulus(input bit gi, input bit gd, input int pct);
        if (gi || !bus.if_req) begin
            if (int'($urandom_range(99)) < pct) begin
                bus.if_req  = 1'b1;
                bus.if_addr = {$urandom(), $urandom()} & ~64'h3;
            end else begin
                bus.if_req = 1'b0;
            end
        end
        if (gd || !bus.d_req) begin
            if (int'($urandom_range(99)) < pct) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(1));
                bus.d_addr  = {$urandom(), $urandom()} & ~64'h7;
                bus.d_wdata = {$urandom(), $urandom()};
            end else begin
                bus.d_req = 1'b0;
            end
        end
    endtask

    // One clock cycle: compare against the model, advance the model, step the clock.
    task automatic runCycle();
        bit free, eg_d, eg_if, e_mreq, e_ifv, e_dv, rst_now;
        @(negedge Clk);
        rst_now = !resetl;
        free    = (cyc >= next_free);
        eg_d    = free && bus.d_req && !(bus.if_req && (starve_m == MAX_DATA_BURST));
        eg_if   = free && bus.if_req && !eg_d;
        e_mreq  = act && (cyc >= gc + 1) && (cyc <= gc + MEM_LAT);
        e_ifv   = act && !own_d && (cyc == gc + MEM_LAT + 1);
        e_dv    = act && own_d && (cyc == gc + MEM_LAT + 1);
        if (e_ifv) exp_if_rdata = p_addr[2] ? p_rdata[63:32] : p_rdata[31:0];
        if (e_dv && !p_we) exp_d_rdata = p_rdata;

        checkOutput("if_gnt",    64'(bus.if_gnt),    64'(eg_if));
        checkOutput("d_gnt",     64'(bus.d_gnt),     64'(eg_d));
        checkOutput("m_req",     64'(bus.m_req),     64'(e_mreq));
        if (e_mreq) begin
            checkOutput("m_addr",  bus.m_addr,         p_addr);
            checkOutput("m_we",    64'(bus.m_we),      64'(p_we));
            checkOutput("m_wdata", bus.m_wdata,        p_wdata);
        end
        checkOutput("if_rvalid", 64'(bus.if_rvalid), 64'(e_ifv));
        checkOutput("d_rvalid",  64'(bus.d_rvalid),  64'(e_dv));
        checkOutput("if_rdata",  64'(bus.if_rdata),  64'(exp_if_rdata));
        checkOutput("d_rdata",   bus.d_rdata,        exp_d_rdata);
        checkOutput("stall_if",  64'(bus.stall_if),  64'(bus.if_req && !e_ifv));
        checkOutput("stall_mem", 64'(bus.stall_mem), 64'(bus.d_req && !e_dv));
`ifdef MEM_ARB_PERF_CNT_EN
        checkOutput("perf_if_wait",   64'(perf_if_wait),   64'(m_wait));
        checkOutput("perf_conflicts", 64'(perf_conflicts), 64'(m_conf));
`endif

        last_gi = 1'b0;
        last_gd = 1'b0;
        if (rst_now) begin
            act          = 1'b0;
            next_free    = cyc + 1;
            starve_m     = 0;
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
            m_wait       = 0;
            m_conf       = 0;
        end else begin
            if (bus.if_req && !eg_if) m_wait++;
            if (free && bus.if_req && bus.d_req) m_conf++;
            if (eg_if || (free && !bus.if_req)) begin
                starve_m = 0;
            end else if (eg_d && bus.if_req && (starve_m < MAX_DATA_BURST)) begin
                starve_m++;
            end
            if (eg_d || eg_if) begin
                act       = 1'b1;
                gc        = cyc;
                own_d     = eg_d;
                p_addr    = eg_d ? bus.d_addr : bus.if_addr;
                p_we      = eg_d && bus.d_we;
                p_wdata   = eg_d ? bus.d_wdata : 64'h0;
                next_free = cyc + MEM_LAT + 2;
            end
            last_gi = eg_if;
            last_gd = eg_d;
        end

        @(posedge Clk);
        cyc++;
        #1;
        if (last_gi || last_gd) begin
            bus.m_rdata = next_rdata;
            p_rdata     = next_rdata;
            next_rdata  = {$urandom(), $urandom()};
        end
    endtask

    // Drop all requests and let any transaction finish.
    task automatic drainIdle();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (MEM_LAT + 3) runCycle();
    endtask

    initial begin
        bit got;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        next_rdata  = {$urandom(), $urandom()};

        resetl = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        resetl = 1'b1;
        $display("[TB] reset released");
        runCycle();

        // Single fetch with upper-word select.
        next_rdata  = 64'hAABBCCDD_11223344;
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h4;
        runCycle();
        bus.if_req = 1'b0;
        repeat (MEM_LAT + 1) runCycle();
        checkOutput("tp1_if_rdata", 64'(bus.if_rdata), 64'hAABBCCDD);
        drainIdle();

        // Simultaneous requests: data wins, fetch waits for its own turn.
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h1000;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 64'h100;
        runCycle();
        bus.d_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            runCycle();
            if (last_gi) begin
                got = 1'b1;
                bus.if_req = 1'b0;
            end
        end
        checkOutput("tp2_fetch_granted", 64'(got), 64'(1));
        drainIdle();

        // Continuous contention: starvation limit lets fetch through.
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        for (int i = 0; i < 24; i++) begin
            runCycle();
            applyStimulus(last_gi, last_gd, 100);
        end
        drainIdle();

        // Store: write enable and address presented, d_rdata untouched.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 64'h40;
        bus.d_wdata = 64'h55;
        runCycle();
        bus.d_req = 1'b0;
        repeat (MEM_LAT + 2) runCycle();

        // Reset during the second access cycle abandons the transaction.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 64'h200;
        runCycle();
        bus.d_req = 1'b0;
        runCycle();
        resetl = 1'b0;
        runCycle();
        resetl = 1'b1;
        checkOutput("tp5_m_req_after_reset", 64'(bus.m_req), 64'(0));
        bus.d_req  = 1'b1;
        bus.d_addr = 64'h208;
        runCycle();
        bus.d_req = 1'b0;
        drainIdle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(last_gi, last_gd, 60);
            runCycle();
        end
        drainIdle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
